// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared FSM state type and next-state rule for the CPU clock controller
`include "clock_defs.vh"
package clock_ctrl_pkg;
  typedef enum logic [1:0] {
    HALT = `CLK_ST_HALT,
    RUN  = `CLK_ST_RUN,
    STEP = `CLK_ST_STEP
  } state_t;
  function automatic state_t fsm_next(state_t s, logic run, logic step, logic hreq);
    return s == HALT ? (run ? RUN : step ? STEP : HALT) :
           s == RUN  ? ((run || hreq) ? HALT : RUN) : HALT;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer, hold-time debounce and registered press pulse
module button_debounce #(
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic clk,
  input  logic res,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = DEBOUNCE_CNT > 1 ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, diff, done;
  // counter runs while the synchronized level disagrees with the accepted one
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    diff = sync_q[1] != level_q;
    done = diff && cnt_q == LAST;
    cnt_d = (!diff || done) ? '0 : cnt_q + CW'(1);
    level_d = done ? ~level_q : level_q;
    press_d = done && !level_q;
  end
  // state registers, cleared on reset
  always_ff @(posedge clk) begin
    if (res) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/clock_defs.vh
`ifndef CLOCK_DEFS_VH
`define CLOCK_DEFS_VH
`define CLK_ST_HALT 2'b00
`define CLK_ST_RUN  2'b01
`define CLK_ST_STEP 2'b10
`endif

// File: rtl/clock_ctrl.sv
// clock_ctrl: button-driven run/halt/step control and prescaler select for the CPU clock
`include "clock_defs.vh"
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 50000,
  parameter logic [1:0] PRESCALER_RST = 2'b11
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_speed,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       halt_req,
  output logic [1:0] prescaler,
  output logic       cpu_en,
  output logic       halted
);
  logic speed_p, run_p, step_p;
  logic [2:0] lvl;
  state_t state_q, state_d;
  logic [1:0] prescaler_q, prescaler_d;
  logic cpu_en_q, halted_q;
  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_speed (
    .clk(clk), .res(res), .btn_raw(btn_speed), .level(lvl[0]), .press(speed_p));
  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_run (
    .clk(clk), .res(res), .btn_raw(btn_run), .level(lvl[1]), .press(run_p));
  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_step (
    .clk(clk), .res(res), .btn_raw(btn_step), .level(lvl[2]), .press(step_p));
  // next state and prescaler; speed presses act regardless of FSM state
  always_comb begin
    state_d = fsm_next(state_q, run_p, step_p, halt_req);
    prescaler_d = prescaler_q + {1'b0, speed_p};
  end
  // FSM with outputs registered as decodes of the next state
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= HALT;
      cpu_en_q <= 1'b0;
      halted_q <= 1'b1;
      prescaler_q <= PRESCALER_RST;
    end else begin
      state_q <= state_d;
      cpu_en_q <= state_d != HALT;
      halted_q <= state_d == HALT;
      prescaler_q <= prescaler_d;
    end
  end
  assign prescaler = prescaler_q;
  assign cpu_en = cpu_en_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed and random stimulus against a behavioural model of clock_ctrl
`include "clock_defs.vh"
module tb_clock_ctrl;
  localparam int N = 4;
  logic clk = 1'b0, res = 1'b1;
  logic btn_speed = 1'b0, btn_run = 1'b0, btn_step = 1'b0, halt_req = 1'b0;
  logic [1:0] prescaler;
  logic cpu_en, halted;
  int errors = 0, checks = 0;
  int dl0[3], dl1[3], run_len[3], acc[3], pr[3];
  int st, presc;
  int en_cnt, fall_cnt;
  logic prev_halted;
  clock_ctrl #(.DEBOUNCE_CNT(N), .PRESCALER_RST(2'b11)) dut (
    .clk(clk), .res(res), .btn_speed(btn_speed), .btn_run(btn_run),
    .btn_step(btn_step), .halt_req(halt_req), .prescaler(prescaler),
    .cpu_en(cpu_en), .halted(halted));
  always #5 clk = ~clk;
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Reference: a button is accepted after its synchronized level (2 cycles late)
  // has disagreed with the accepted level for N consecutive cycles.
  task automatic model_step();
    int r[3];
    int np[3];
    r = '{int'(btn_speed), int'(btn_run), int'(btn_step)};
    if (res) begin
      for (int i = 0; i < 3; i++) begin
        dl0[i] = 0; dl1[i] = 0; run_len[i] = 0; acc[i] = 0; pr[i] = 0;
      end
      st = `CLK_ST_HALT;
      presc = 3;
    end else begin
      for (int i = 0; i < 3; i++) begin
        np[i] = 0;
        if (dl1[i] != acc[i]) begin
          run_len[i]++;
          if (run_len[i] == N) begin
            acc[i] = 1 - acc[i];
            run_len[i] = 0;
            np[i] = acc[i];
          end
        end else run_len[i] = 0;
      end
      presc = (presc + pr[0]) % 4;
      if (st == `CLK_ST_HALT) st = pr[1] ? `CLK_ST_RUN : pr[2] ? `CLK_ST_STEP : `CLK_ST_HALT;
      else if (st == `CLK_ST_RUN) st = (pr[1] || halt_req) ? `CLK_ST_HALT : `CLK_ST_RUN;
      else st = `CLK_ST_HALT;
      for (int i = 0; i < 3; i++) begin
        dl1[i] = dl0[i]; dl0[i] = r[i]; pr[i] = np[i];
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("prescaler", int'(prescaler), presc);
    chk("cpu_en", int'(cpu_en), int'(st != `CLK_ST_HALT));
    chk("halted", int'(halted), int'(st == `CLK_ST_HALT));
    if (cpu_en) en_cnt++;
    if (prev_halted && !halted) fall_cnt++;
    prev_halted = halted;
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    int exp_p;
    prev_halted = 1'b1;
    ticks(3);
    chk("reset_prescaler", int'(prescaler), 3);
    chk("reset_halted", int'(halted), 1);
    chk("reset_cpu_en", int'(cpu_en), 0);
    res = 1'b0;
    ticks(2);
    exp_p = 3;
    for (int k = 0; k < 4; k++) begin
      btn_speed = 1'b1;
      ticks(6);
      chk("speed_before_7", int'(prescaler), exp_p);
      tick();
      exp_p = (exp_p + 1) % 4;
      chk("speed_at_7", int'(prescaler), exp_p);
      ticks(3);
      btn_speed = 1'b0;
      ticks(10);
    end
    chk("speed_wrap_final", int'(prescaler), 3);
    en_cnt = 0;
    btn_step = 1'b1; ticks(3); btn_step = 1'b0; ticks(10);
    chk("short_step_en", en_cnt, 0);
    en_cnt = 0;
    btn_step = 1'b1; ticks(8); btn_step = 1'b0; ticks(10);
    chk("step_en_once", en_cnt, 1);
    chk("step_back_halt", int'(halted), 1);
    btn_run = 1'b1; ticks(8); btn_run = 1'b0; ticks(10);
    chk("run_cpu_en", int'(cpu_en), 1);
    chk("run_halted", int'(halted), 0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("hreq_cpu_en", int'(cpu_en), 0);
    chk("hreq_halted", int'(halted), 1);
    ticks(3);
    btn_run = 1'b1; btn_step = 1'b1; ticks(8);
    btn_run = 1'b0; btn_step = 1'b0;
    en_cnt = 0; ticks(10);
    chk("both_run_en", en_cnt, 10);
    btn_run = 1'b1; ticks(8); btn_run = 1'b0; ticks(10);
    chk("both_back_halt", int'(halted), 1);
    fall_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      btn_run = 1'b1; ticks(2); btn_run = 1'b0; ticks(2);
    end
    btn_run = 1'b1; ticks(10); btn_run = 1'b0; ticks(10);
    chk("bounce_one_run", fall_cnt, 1);
    chk("bounce_running", int'(cpu_en), 1);
    btn_speed = 1'b1; ticks(4);
    res = 1'b1; btn_speed = 1'b0; ticks(2);
    res = 1'b0; ticks(12);
    chk("rst_mid_prescaler", int'(prescaler), 3);
    chk("rst_mid_halted", int'(halted), 1);
    btn_speed = 1'b1; ticks(2);
    res = 1'b1; ticks(2);
    res = 1'b0; ticks(9);
    chk("held_at_release", int'(prescaler), 0);
    btn_speed = 1'b0; ticks(10);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) btn_speed = ~btn_speed;
      if ($urandom_range(9) == 0) btn_run = ~btn_run;
      if ($urandom_range(7) == 0) btn_step = ~btn_step;
      halt_req = $urandom_range(15) == 0;
      res = $urandom_range(199) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
